pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central run-control and hazard sequencer for the 5-stage RISC-V pipeline. It owns PC/IF-ID write enables and the per-stage flush/bubble controls. It resolves load-use stalls, taken-branch flushes and fault halts in one place, and adds run/pause/single-step control plus a sticky fault cause and performance counters. It sits beside the datapath, reading decode/execute/memory status and driving the pipeline-register controls.

## Interface
- DRAIN_CYCLES, 3, cycles spent in DRAIN so in-flight instructions retire (≥1)
- CNT_W, 16, width of the performance counters
- clock  in  1  pipeline clock, rising edge
- reset  in  1  reset is asynchronous and active-low
- run_req  in  1  level; 1 = execute continuously, 0 = pause
- step_req  in  1  one-cycle pulse; issue one instruction while in IDLE
- clear_req  in  1  one-cycle pulse; leave HALT and clear cause
- id_rs1, id_rs2  in  5  source registers of the instruction in IF/ID
- id_uses_rs1, id_uses_rs2  in  1  instruction in IF/ID reads rs1/rs2
- ex_memread  in  1  instruction in ID/EX is a load
- ex_rd  in  5  destination of the instruction in ID/EX
- mem_branch_taken  in  1  branch in EX/MEM resolved taken (target on PC mux)
- err_fetch  in  1  invalid fetch address
- err_decode  in  1  invalid opcode or function in IF/ID
- err_mem  in  1  invalid data address in EX/MEM
- pc_write  out  1  PC loads next-PC this edge
- if_id_write  out  1  IF/ID captures this edge
- if_id_flush  out  1  IF/ID cleared to NOP this edge
- id_ex_bubble  out  1  ID/EX captures zeroed control bits (stall/idle)
- id_ex_flush  out  1  ID/EX cleared this edge
- ex_mem_flush  out  1  EX/MEM control bits cleared this edge
- state  out  3  IDLE=0, RUN=1, STEP=2, DRAIN=3, HALT=4
- halted  out  1  state==HALT
- cause  out  3  sticky one-hot fault: [2]=mem, [1]=decode, [0]=fetch
- stall_count  out  CNT_W  load-use stall cycles, saturating
- flush_count  out  CNT_W  taken-branch flush events, saturating

## Operation
- Control outputs are combinational from state and inputs. State, drain counter, cause and counters are registered.
- Load-use hazard: lu = ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Frozen state (IDLE, HALT, DRAIN): pc_write=0, if_id_write=0, id_ex_bubble=1, all flushes 0 except fault flushes in DRAIN.
- Advancing state (RUN, STEP), priority high to low:
  - err_mem: if_id_flush, id_ex_flush, ex_mem_flush.
  - err_decode: if_id_flush, id_ex_bubble.
  - err_fetch: if_id_flush.
  - mem_branch_taken: pc_write=1, if_id_flush, id_ex_flush, ex_mem_flush; flush_count++.
  - lu: pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count++.
  - Otherwise: pc_write=1, if_id_write=1, all others 0.
- Transitions:
  - IDLE→RUN on run_req. IDLE→STEP on step_req (run_req has priority).
  - RUN→DRAIN on any error, or when run_req=0.
  - STEP→DRAIN after the first cycle with pc_write=1 or any error. It stays in STEP while lu stalls.
  - DRAIN: counter loads DRAIN_CYCLES-1 on entry and decrements each cycle. At 0 it goes →HALT if cause!=0, else →IDLE. run_req during DRAIN is ignored until IDLE.
  - HALT→IDLE on clear_req, which also zeroes cause. run_req and step_req are ignored in HALT.
- Faults:
  - cause captures only while it is 0, so the first fault is sticky. Simultaneous faults record only the highest-priority bit (mem>decode>fetch).
  - err_mem is honored in RUN, STEP and DRAIN. In DRAIN it applies the three flushes, records cause if empty, and does not restart the drain counter.
  - err_fetch and err_decode are ignored outside RUN/STEP.
- Counters saturate at 2^CNT_W-1 and clear only on reset.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, cause=0, both counters 0, drain counter 0, halted=0.
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, all flushes 0.
- Stall/flush/write outputs respond in the same cycle as their inputs; zero-latency combinational path.
- State changes take effect on the next rising edge. Fault to HALT takes 1 + DRAIN_CYCLES edges.
- A load-use stall lasts exactly one cycle per hazard, since ID/EX then holds a bubble.
- Branch and load-use in the same cycle: branch wins. Stall is not counted; flush is counted.
- Reset asserted mid-DRAIN or mid-STEP: immediate return to reset values; cause is lost.

## Test plan
- Reset, run_req=1 next cycle → cycle 1 state=RUN, pc_write=1, if_id_write=1, id_ex_bubble=0.
- RUN, ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle → pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_count=1.
- Same cycle as above plus mem_branch_taken=1 → pc_write=1, three flushes=1; flush_count=1, stall_count unchanged.
- RUN, err_mem and err_decode together → three flushes, cause=3'b100; DRAIN for 3 cycles, then state=HALT, halted=1; clear_req → IDLE, cause=0.
- IDLE, step_req with lu active for 2 cycles → STEP held 2 cycles with pc_write=0, pc_write=1 on cycle 3; DRAIN 3 cycles, then IDLE.
- CNT_W=2, 5 load-use stalls → stall_count=3 (saturated); reset mid-DRAIN → state=IDLE, counters 0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Run-control and hazard sequencer for the 5-stage pipeline: drives PC/IF-ID enables,
// per-stage flush/bubble controls, run/step/drain/halt sequencing, sticky fault cause and counters.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             clear_req,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             err_fetch,
  input  logic             err_decode,
  input  logic             err_mem,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [2:0]       state,
  output logic             halted,
  output logic [2:0]       cause,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t           state_q, state_nxt;
  logic [DW-1:0]    drain_q, drain_nxt;
  logic [2:0]       cause_q, cause_nxt;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lu, any_err, advancing;
  logic             stall_inc, flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Only the highest-priority fault is recorded when several fire together.
  function automatic logic [2:0] fault_onehot(input logic m, input logic d, input logic f);
    if (m)      return 3'b100;
    else if (d) return 3'b010;
    else if (f) return 3'b001;
    return 3'b000;
  endfunction

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign any_err   = err_mem || err_decode || err_fetch;
  assign advancing = (state_q == RUN) || (state_q == STEP);

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (advancing) begin
      id_ex_bubble = 1'b0;
      if (err_mem) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (err_decode) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (err_fetch) begin
        if_id_flush = 1'b1;
      end else if (mem_branch_taken) begin
        pc_write     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        flush_inc    = 1'b1;
      end else if (lu) begin
        id_ex_bubble = 1'b1;
        stall_inc    = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end else if ((state_q == DRAIN) && err_mem) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    drain_nxt = drain_q;
    cause_nxt = cause_q;
    if (cause_q == 3'b000) begin
      if (advancing)
        cause_nxt = fault_onehot(err_mem, err_decode, err_fetch);
      else if ((state_q == DRAIN) && err_mem)
        cause_nxt = 3'b100;
    end
    case (state_q)
      IDLE: begin
        if (run_req)       state_nxt = RUN;
        else if (step_req) state_nxt = STEP;
      end
      RUN: begin
        if (any_err || !run_req) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_LOAD;
        end
      end
      STEP: begin
        if (any_err || pc_write) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // A fault captured in the final drain cycle must still land in HALT.
        if (drain_q == '0) state_nxt = (cause_nxt != 3'b000) ? HALT : IDLE;
        else               drain_nxt = drain_q - DW'(1);
      end
      HALT: begin
        if (clear_req) begin
          state_nxt = IDLE;
          cause_nxt = 3'b000;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      cause_q <= 3'b000;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_nxt;
      drain_q <= drain_nxt;
      cause_q <= cause_nxt;
      if (stall_inc) stall_q <= sat_inc(stall_q);
      if (flush_inc) flush_q <= sat_inc(flush_q);
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == HALT);
  assign cause       = cause_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a 16-bit-counter instance for sequencing and a
// 2-bit-counter instance for saturation, driven from one linear stimulus sequence.
module tb_pipeline_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic reset2 = 1'b0;
  logic run_req = 0, step_req = 0, clear_req = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_memread = 0;
  logic mem_branch_taken = 0, err_fetch = 0, err_decode = 0, err_mem = 0;

  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_flush, ex_mem_flush, halted;
  logic [2:0] state, cause;
  logic [15:0] stall_count, flush_count;

  logic pc_write2, if_id_write2, if_id_flush2, id_ex_bubble2, id_ex_flush2, ex_mem_flush2, halted2;
  logic [2:0] state2, cause2;
  logic [1:0] stall_count2, flush_count2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipeline_sequencer #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .run_req(run_req), .step_req(step_req), .clear_req(clear_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
    .err_fetch(err_fetch), .err_decode(err_decode), .err_mem(err_mem),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .state(state), .halted(halted), .cause(cause),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_sequencer #(.DRAIN_CYCLES(3), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset2), .run_req(run_req), .step_req(step_req), .clear_req(clear_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
    .err_fetch(err_fetch), .err_decode(err_decode), .err_mem(err_mem),
    .pc_write(pc_write2), .if_id_write(if_id_write2), .if_id_flush(if_id_flush2),
    .id_ex_bubble(id_ex_bubble2), .id_ex_flush(id_ex_flush2), .ex_mem_flush(ex_mem_flush2),
    .state(state2), .halted(halted2), .cause(cause2),
    .stall_count(stall_count2), .flush_count(flush_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Load-use on rs2 = x5 against a load writing x5.
  task automatic set_lu(input logic on);
    ex_memread  = on;
    ex_rd       = on ? 5'd5 : 5'd0;
    id_rs2      = on ? 5'd5 : 5'd0;
    id_uses_rs2 = on;
  endtask

  task automatic chk_frozen(input string tag);
    chk({tag, "_pcw"}, pc_write, 0);
    chk({tag, "_ifw"}, if_id_write, 0);
    chk({tag, "_bub"}, id_ex_bubble, 1);
    chk({tag, "_fl"}, {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b000);
  endtask

  initial begin
    #1;
    chk("rst_state", state, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", cause, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_flush", flush_count, 0);
    chk_frozen("rst");
    tick();
    reset = 1'b1;
    run_req = 1'b1;
    #1;
    chk("idle_pcw", pc_write, 0);
    tick();
    chk("run_state", state, 1);
    chk("run_pcw", pc_write, 1);
    chk("run_ifw", if_id_write, 1);
    chk("run_bub", id_ex_bubble, 0);

    set_lu(1'b1);
    #1;
    chk("lu_pcw", pc_write, 0);
    chk("lu_ifw", if_id_write, 0);
    chk("lu_bub", id_ex_bubble, 1);
    chk("lu_fl", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b000);
    tick();
    set_lu(1'b0);
    #1;
    chk("lu_stall_cnt", stall_count, 1);
    chk("lu_state", state, 1);

    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    chk("x0_no_stall", pc_write, 1);
    tick();
    ex_memread = 1'b0; id_uses_rs1 = 1'b0;
    chk("x0_stall_cnt", stall_count, 1);

    set_lu(1'b1);
    mem_branch_taken = 1'b1;
    #1;
    chk("br_pcw", pc_write, 1);
    chk("br_ifw", if_id_write, 0);
    chk("br_fl", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
    tick();
    set_lu(1'b0);
    mem_branch_taken = 1'b0;
    #1;
    chk("br_flush_cnt", flush_count, 1);
    chk("br_stall_cnt", stall_count, 1);
    chk("br_state", state, 1);

    err_mem = 1'b1; err_decode = 1'b1;
    #1;
    chk("em_fl", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
    chk("em_pcw", pc_write, 0);
    tick();
    err_mem = 1'b0; err_decode = 1'b0;
    #1;
    chk("em_state", state, 3);
    chk("em_cause", cause, 3'b100);
    chk_frozen("drain");
    tick();
    tick();
    chk("em_drain3", state, 3);
    tick();
    chk("em_halt", state, 4);
    chk("em_halted", halted, 1);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("halt_ignore", state, 4);
    run_req = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_state", state, 0);
    chk("clr_cause", cause, 0);

    step_req = 1'b1;
    set_lu(1'b1);
    tick();
    step_req = 1'b0;
    #1;
    chk("st1_state", state, 2);
    chk("st1_pcw", pc_write, 0);
    tick();
    chk("st2_state", state, 2);
    chk("st2_pcw", pc_write, 0);
    tick();
    set_lu(1'b0);
    #1;
    chk("st3_state", state, 2);
    chk("st3_pcw", pc_write, 1);
    tick();
    chk("st_drain", state, 3);
    chk("st_stall_cnt", stall_count, 3);
    tick();
    tick();
    chk("st_drain3", state, 3);
    tick();
    chk("st_idle", state, 0);
    chk("st_cause", cause, 0);

    err_fetch = 1'b1;
    #1;
    chk("idle_ef_fl", if_id_flush, 0);
    tick();
    err_fetch = 1'b0;
    chk("idle_ef_cause", cause, 0);
    chk("idle_ef_state", state, 0);

    run_req = 1'b1;
    tick();
    err_fetch = 1'b1;
    #1;
    chk("ef_flush", if_id_flush, 1);
    chk("ef_pcw", pc_write, 0);
    tick();
    err_fetch = 1'b0;
    run_req = 1'b0;
    chk("ef_cause", cause, 3'b001);
    chk("ef_state", state, 3);
    tick();
    tick();
    tick();
    chk("ef_halt", state, 4);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("ef_clr", state, 0);

    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    chk("dm_state", state, 3);
    chk("dm_cause0", cause, 0);
    err_mem = 1'b1;
    #1;
    chk("dm_fl", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
    chk("dm_ifw", if_id_write, 0);
    tick();
    err_mem = 1'b0;
    chk("dm_cause", cause, 3'b100);
    chk("dm_drain2", state, 3);
    tick();
    chk("dm_drain3", state, 3);
    tick();
    chk("dm_halt", state, 4);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("dm_clr", state, 0);

    reset2 = 1'b1;
    run_req = 1'b1;
    tick();
    chk("sat_run", state2, 1);
    set_lu(1'b1);
    repeat (5) tick();
    set_lu(1'b0);
    chk("sat_stall2", stall_count2, 3);
    chk("sat_stall16", stall_count, 8);
    run_req = 1'b0;
    tick();
    chk("sat_drain", state2, 3);
    tick();
    reset = 1'b0;
    reset2 = 1'b0;
    #1;
    chk("mr_state", state, 0);
    chk("mr_state2", state2, 0);
    chk("mr_stall", stall_count, 0);
    chk("mr_flush", flush_count, 0);
    chk("mr_stall2", stall_count2, 0);
    chk("mr_cause", cause, 0);
    chk_frozen("mr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
